// File: rtl/ov7670_capture.sv
// OV7670 pixel capture: registers sensor pins, packs RGB565 byte pairs into RGB444
// and writes them to a line-structured frame buffer, flagging overruns and short frames.
module ov7670_capture #(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240,
    parameter int ADDR_W   = 17
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              enable,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        D_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              frame_done,
    output logic              overflow,
    output logic              short_frame
);

    localparam int COL_W     = $clog2(H_PIXELS + 1);
    localparam int ROW_W_MIN = $clog2(V_LINES + 1);
    localparam int ROW_W     = (ROW_W_MIN > 9) ? ROW_W_MIN : 9;

    localparam logic [COL_W-1:0]  H_LIM     = COL_W'(H_PIXELS);
    localparam logic [ROW_W-1:0]  V_LIM     = ROW_W'(V_LINES);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(H_PIXELS);

    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } state_t;

    state_t state;
    state_t next_state;

    logic              vs_q;
    logic              hr_q;
    logic [7:0]        d_q;
    logic              vs_prev;
    logic              hr_prev;
    logic              phase;
    logic [7:0]        byte1;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] row_base;
    logic              start_frame;
    logic              end_frame;

    logic vs_rise;
    logic vs_fall;
    logic hr_fall;
    logic in_range;

    assign vs_rise  = vs_q & ~vs_prev;
    assign vs_fall  = ~vs_q & vs_prev;
    assign hr_fall  = ~hr_q & hr_prev;
    assign in_range = (col < H_LIM) && (row < V_LIM);

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            vs_q    <= 1'b0;
            hr_q    <= 1'b0;
            d_q     <= 8'd0;
            vs_prev <= 1'b0;
            hr_prev <= 1'b0;
        end else begin
            vs_q    <= vsync;
            hr_q    <= href;
            d_q     <= D_data;
            vs_prev <= vs_q;
            hr_prev <= hr_q;
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_SOF;
        end else begin
            state <= next_state;
        end
    end

    // enable only matters at the vsync falling edge; a running frame always completes
    always_comb begin
        next_state  = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (vs_fall && enable) begin
                    next_state  = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    next_state = WAIT_SOF;
                    end_frame  = 1'b1;
                end
            end
            default: next_state = WAIT_SOF;
        endcase
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 12'd0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            phase       <= 1'b0;
            byte1       <= 8'd0;
            col         <= '0;
            row         <= '0;
            row_base    <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (start_frame) begin
                col      <= '0;
                row      <= '0;
                row_base <= '0;
                overflow <= 1'b0;
                phase    <= 1'b0;
            end else if (state == ACTIVE) begin
                if (hr_q) begin
                    phase <= ~phase;
                    if (!phase) begin
                        byte1 <= d_q;
                    end else if (in_range) begin
                        wr_en   <= 1'b1;
                        wr_addr <= row_base + ADDR_W'(col);
                        wr_data <= {byte1[7:4], byte1[2:0], d_q[7], d_q[4:1]};
                        col     <= col + 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    // A dangling byte1 is dropped here; empty lines leave the row untouched
                    phase <= 1'b0;
                    if (hr_fall) begin
                        if ((col != '0) && (row < V_LIM)) begin
                            row      <= row + 1'b1;
                            row_base <= row_base + ADDR_STEP;
                        end
                        col <= '0;
                    end
                end
                if (end_frame) begin
                    frame_done  <= 1'b1;
                    short_frame <= (row < V_LIM);
                end
            end else begin
                phase <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a reduced 16x8 geometry; a monitor records
// every write and frame_done pulse, and the main sequence checks them.
module tb_ov7670_capture;

    localparam int H = 16;
    localparam int V = 8;
    localparam int AW = 8;

    logic          pclk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [7:0]    D_data = 8'd0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          frame_done;
    logic          overflow;
    logic          short_frame;

    int tests = 0;
    int failures = 0;

    int            cyc = 0;
    logic [AW-1:0] wq_addr[$];
    logic [11:0]   wq_data[$];
    int            wq_cyc[$];
    int            fd_count = 0;
    int            fd_cyc = 0;
    logic          fd_short = 1'b0;

    ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .pclk(pclk),
        .reset(reset),
        .enable(enable),
        .vsync(vsync),
        .href(href),
        .D_data(D_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_done(frame_done),
        .overflow(overflow),
        .short_frame(short_frame)
    );

    initial forever #5 pclk = ~pclk;

    // Outputs are sampled 1 ns after each rising edge
    initial forever begin
        @(posedge pclk);
        cyc++;
        #1;
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            wq_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
            fd_short = short_frame;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic applyStimulus(input int nbytes, input logic [7:0] b1, input logic [7:0] b2);
        for (int i = 0; i < nbytes; i++) begin
            href = 1'b1;
            D_data = (i % 2 == 0) ? b1 : b2;
            @(negedge pclk);
        end
        href = 1'b0;
        D_data = 8'd0;
    endtask

    task automatic clearLog();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        fd_count = 0;
    endtask

    task automatic vsyncPulse();
        vsync = 1'b1;
        tick(8);
        vsync = 1'b0;
        tick(4);
    endtask

    task automatic endFrame(output int vs_cyc);
        tick(4);
        vsync = 1'b1;
        vs_cyc = cyc;
        tick(4);
    endtask

    initial begin
        int c0;
        int vcyc;
        int bad;

        tick(12);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rst_flags", 32'({frame_done, overflow, short_frame}), 32'd0);
        reset = 1'b1;
        enable = 1'b1;
        tick(10);
        applyStimulus(8, 8'hCA, 8'hCA);
        tick(20);
        checkOutput("idle_writes", 32'(wq_addr.size()), 32'd0);
        checkOutput("idle_frame_done", 32'(fd_count), 32'd0);

        // First frame: four pixels of 0xCA
        vsyncPulse();
        clearLog();
        c0 = cyc;
        applyStimulus(8, 8'hCA, 8'hCA);
        tick(6);
        checkOutput("burst_count", 32'(wq_addr.size()), 32'd4);
        if (wq_addr.size() == 4) begin
            checkOutput("burst_latency", 32'(wq_cyc[0]), 32'(c0 + 3));
            checkOutput("burst_period", 32'(wq_cyc[1] - wq_cyc[0]), 32'd2);
            checkOutput("burst_period_last", 32'(wq_cyc[3] - wq_cyc[2]), 32'd2);
            checkOutput("burst_data", 32'(wq_data[0]), 32'h0C55);
            checkOutput("burst_addr0", 32'(wq_addr[0]), 32'd0);
            checkOutput("burst_addr3", 32'(wq_addr[3]), 32'd3);
        end
        checkOutput("hold_addr", 32'(wr_addr), 32'd3);
        checkOutput("hold_data", 32'(wr_data), 32'h0C55);
        endFrame(vcyc);
        checkOutput("fd_count_short", 32'(fd_count), 32'd1);
        checkOutput("fd_latency", 32'(fd_cyc), 32'(vcyc + 2));
        checkOutput("fd_short_1line", 32'(fd_short), 32'd1);

        // Full frame of 0xF8,0x00 pixels
        vsyncPulse();
        clearLog();
        repeat (V) begin
            applyStimulus(2 * H, 8'hF8, 8'h00);
            tick(4);
        end
        endFrame(vcyc);
        checkOutput("full_count", 32'(wq_addr.size()), 32'(H * V));
        bad = 0;
        foreach (wq_addr[i]) begin
            if (int'(wq_addr[i]) != i || wq_data[i] !== 12'hF00) bad++;
        end
        checkOutput("full_sequence", 32'(bad), 32'd0);
        checkOutput("full_fd_count", 32'(fd_count), 32'd1);
        checkOutput("full_short", 32'(fd_short), 32'd0);
        checkOutput("full_overflow", 32'(overflow), 32'd0);

        // Long line, 3-byte line, then normal lines
        vsyncPulse();
        clearLog();
        applyStimulus(2 * H + 2, 8'hF8, 8'h00);
        tick(4);
        checkOutput("long_overflow", 32'(overflow), 32'd1);
        applyStimulus(3, 8'hCA, 8'hCA);
        tick(4);
        repeat (V - 2) begin
            applyStimulus(2 * H, 8'hF8, 8'h00);
            tick(4);
        end
        endFrame(vcyc);
        checkOutput("long_count", 32'(wq_addr.size()), 32'(H + 1 + (V - 2) * H));
        if (wq_addr.size() == H + 1 + (V - 2) * H) begin
            checkOutput("long_line0_last", 32'(wq_addr[H - 1]), 32'(H - 1));
            checkOutput("short_line_addr", 32'(wq_addr[H]), 32'(H));
            checkOutput("short_line_data", 32'(wq_data[H]), 32'h0C55);
            checkOutput("line2_addr", 32'(wq_addr[H + 1]), 32'(2 * H));
            checkOutput("line2_data", 32'(wq_data[H + 1]), 32'h0F00);
            checkOutput("long_last_addr", 32'(wq_addr[H + (V - 2) * H]), 32'(H * V - 1));
        end
        checkOutput("long_short", 32'(fd_short), 32'd0);
        checkOutput("long_overflow_end", 32'(overflow), 32'd1);

        // Short frame, then a frame with capture disarmed
        vsyncPulse();
        checkOutput("sof_clears_overflow", 32'(overflow), 32'd0);
        clearLog();
        repeat (3) begin
            applyStimulus(2 * H, 8'hF8, 8'h00);
            tick(4);
        end
        endFrame(vcyc);
        checkOutput("short_fd_count", 32'(fd_count), 32'd1);
        checkOutput("short_flag", 32'(fd_short), 32'd1);
        enable = 1'b0;
        vsyncPulse();
        clearLog();
        applyStimulus(2 * H, 8'hF8, 8'h00);
        tick(4);
        endFrame(vcyc);
        checkOutput("disabled_writes", 32'(wq_addr.size()), 32'd0);
        checkOutput("disabled_fd", 32'(fd_count), 32'd0);

        // Reset while the third pixel sits in phase 1
        enable = 1'b1;
        vsyncPulse();
        clearLog();
        applyStimulus(6, 8'hCA, 8'hCA);
        reset = 1'b0;
        tick(3);
        checkOutput("midrst_writes", 32'(wq_addr.size()), 32'd2);
        checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("midrst_wr_addr", 32'(wr_addr), 32'd0);
        reset = 1'b1;
        tick(2);
        applyStimulus(8, 8'hF8, 8'h00);
        tick(4);
        checkOutput("post_rst_no_resume", 32'(wq_addr.size()), 32'd2);
        vsyncPulse();
        clearLog();
        applyStimulus(4, 8'hF8, 8'h00);
        tick(4);
        checkOutput("post_rst_count", 32'(wq_addr.size()), 32'd2);
        if (wq_addr.size() == 2) begin
            checkOutput("post_rst_addr0", 32'(wq_addr[0]), 32'd0);
            checkOutput("post_rst_addr1", 32'(wq_addr[1]), 32'd1);
        end
        endFrame(vcyc);
        checkOutput("post_rst_short", 32'(fd_short), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
